// File: rtl/id_inst_buffer.sv
// -----------------------------------------------------------------------------
// id_inst_buffer
//
// Instruction buffer between IF and ID. A circular FIFO of {pc, inst} pairs
// with valid/ready handshakes on both sides. The head entry is shown on out_*
// without waiting a cycle. When the buffer is empty, out_pc and out_inst are
// forced to zero so that ID decodes a NOP on a bubble.
//
// Two flush modes are provided:
//   flush      - drop every entry, including this cycle's push.
//   flush_keep - keep only the oldest entry that survives this cycle's pop and
//                push (the branch delay slot), and drop the rest.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush, flush_keep   flush controls (flush has priority)
//   in_valid/in_ready   IF-side handshake, with in_pc / in_inst
//   out_valid/out_ready ID-side handshake, with out_pc / out_inst
//   count               current occupancy (0..DEPTH)
//   almost_full         count >= AFULL_TH
// -----------------------------------------------------------------------------
module id_inst_buffer #(
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     flush_keep,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;
  localparam ptr_t AFULL_W = ptr_t'(AFULL_TH);

  logic [63:0] mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t rd_step;
  logic full, empty, push, pop, survivor, mem_we;

  // All status outputs come from the registered pointers only.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                       (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= AFULL_W);

  // There is no bypass: a full buffer refuses input even while popping.
  assign in_ready  = ~full & ~rst;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc   = out_valid ? mem[rd_ptr_q[PW-1:0]][63:32] : 32'b0;
  assign out_inst = out_valid ? mem[rd_ptr_q[PW-1:0]][31:0]  : 32'b0;

  always_comb begin
    rd_step  = rd_ptr_q + {{PW{1'b0}}, pop};
    // Something survives when an entry is left after the pop (count - pop is
    // nonzero), or when this cycle pushes an entry.
    survivor = (count != {{PW{1'b0}}, pop}) | push;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    rd_ptr_d = rd_step;
    mem_we   = push;
    if (flush) begin
      // Collapse to empty at the current read position. The push is dropped.
      wr_ptr_d = rd_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_we   = 1'b0;
    end else if (flush_keep) begin
      // The first survivor is at rd_step: either the remaining head, or the
      // pushed entry when nothing remains. In the second case
      // rd_step == wr_ptr_q, so the normal write puts it in place.
      rd_ptr_d = rd_step;
      wr_ptr_d = rd_step + {{PW{1'b0}}, survivor};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; entries outside [rd, wr) are don't-care.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[PW-1:0]] <= {in_pc, in_inst};
    end
  end

endmodule
